ls_bus_responder: RTL and testbench

- Target-side (responder) end of the external load/store bus.
- Accepts single-beat read/write requests from the load/store controller's bus interface (en/wr_en/addr/wr_data/access size).
- Performs the access on an internal byte-lane data RAM after a programmable number of wait states.
- Returns read data with a one-cycle bus_ack that releases the core's stalled fetch.

---
 rtl/ls_bus_pkg.sv | 55 +++++
 rtl/ls_bus_responder_if.sv | 39 +++
 rtl/ls_bus_resp_ram.sv | 42 ++++
 rtl/ls_bus_responder.sv | 145 ++++++++++++++
 tb/tb_ls_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_bus_pkg.sv
// Shared definitions for the load/store bus responder: access sizes, FSM
// encoding, the latched request payload and lane/byte-enable helpers.
package ls_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_e;

  // Request fields captured in IDLE (address is held separately, its width is a parameter)
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
  } req_t;

  // Byte enables for a store; all-zero marks a misaligned store that must be dropped
  function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    byte_en = '0;
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: if (!off[0]) byte_en = 4'b0011 << off;
      default: if (off == 2'b00) byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the unshifted source value across the lanes it may land in
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] wd);
    case (size)
      SZ_BYTE: lane_data = {4{wd[7:0]}};
      SZ_HALF: lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Alignment check independent of direction (size 11 behaves as word)
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ls_bus_responder_if.sv
// Load/store bus between the initiator (master) and the responder (slave).
// bus_err exists only when LS_BUS_RESP_ERR_EN is defined.
interface ls_bus_responder_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              ls_bus_en;
  logic              ls_bus_wr_en;
  logic [ADDR_W-1:0] ls_bus_addr;
  logic [31:0]       ls_bus_wr_data;
  logic [1:0]        ls_access_size;
  logic              bus_ack;
  logic [31:0]       ext_read_data;
  logic              bus_busy;
`ifdef LS_BUS_RESP_ERR_EN
  logic              bus_err;

  modport slave (
    input  ls_bus_en, ls_bus_wr_en, ls_bus_addr, ls_bus_wr_data, ls_access_size,
    output bus_ack, ext_read_data, bus_busy, bus_err
  );

  modport master (
    output ls_bus_en, ls_bus_wr_en, ls_bus_addr, ls_bus_wr_data, ls_access_size,
    input  bus_ack, ext_read_data, bus_busy, bus_err
  );
`else
  modport slave (
    input  ls_bus_en, ls_bus_wr_en, ls_bus_addr, ls_bus_wr_data, ls_access_size,
    output bus_ack, ext_read_data, bus_busy
  );

  modport master (
    output ls_bus_en, ls_bus_wr_en, ls_bus_addr, ls_bus_wr_data, ls_access_size,
    input  bus_ack, ext_read_data, bus_busy
  );
`endif

endinterface

// File: rtl/ls_bus_resp_ram.sv
// Single-port data RAM, 32-bit words with byte-write enables and a registered
// read port. The read register is cleared on reset or on request so the
// responder can present zero on write and out-of-window acks; the array itself
// is never reset.
module ls_bus_resp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          clr,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  // Byte-lane writes
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; holds its value when neither read nor clear is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ls_bus_responder.sv
// Target-side responder of the external load/store bus. Latches a single-beat
// request in IDLE, waits WAIT_CYCLES, performs the RAM access and pulses
// bus_ack for one cycle. Optional: define LS_BUS_RESP_ERR_EN to add bus_err,
// flagging out-of-window or misaligned accesses alongside bus_ack.
module ls_bus_responder
  import ls_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BASE_ADDR   = 32'h4000,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  ls_bus_responder_if.slave bus
);

  localparam int unsigned RAM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WIN_BYTES = 4 * MEM_DEPTH;

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              latch;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic              ack_q, busy_q, ack_n;
  logic              ram_we, ram_re, ram_clr;
  logic [31:0]       ram_q;

  logic [31:0]       addr_ext, rel;
  logic              in_win;
  logic [1:0]        off;
  logic [BE_W-1:0]   be;
  logic [RAM_AW-1:0] word_idx;

  // Window decode and lane selection from the latched request
  always_comb begin
    addr_ext = 32'(addr_q);
    rel      = addr_ext - BASE_ADDR;
    in_win   = (addr_ext >= BASE_ADDR) && (rel < WIN_BYTES);
    off      = addr_q[1:0];
    be       = byte_en(req_q.size, off);
    word_idx = RAM_AW'(rel >> 2);
  end

  // Next-state, wait counter and RAM control
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    latch   = 1'b0;
    ack_n   = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    ram_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ls_bus_en) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_n = ACCESS;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_n = ACCESS;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        state_n = ACK;
        ack_n   = 1'b1;
        if (req_q.wr) begin
          ram_clr = 1'b1;
          ram_we  = in_win && (be != '0) && !rst;
        end else if (in_win) begin
          ram_re  = 1'b1;
        end else begin
          ram_clr = 1'b1;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, request latch and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ack_q   <= ack_n;
      busy_q  <= (state_n != IDLE);
      if (latch) begin
        req_q.wr   <= bus.ls_bus_wr_en;
        req_q.size <= bus.ls_access_size;
        req_q.data <= bus.ls_bus_wr_data;
        addr_q     <= bus.ls_bus_addr;
      end
    end
  end

  ls_bus_resp_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .be    (be),
    .addr  (word_idx),
    .wdata (lane_data(req_q.size, req_q.data)),
    .re    (ram_re),
    .clr   (ram_clr),
    .rdata (ram_q)
  );

  assign bus.bus_ack       = ack_q;
  assign bus.bus_busy      = busy_q;
  assign bus.ext_read_data = ram_q;

`ifdef LS_BUS_RESP_ERR_EN
  logic err_q;

  // Error flag rides with the ack of a bad access
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= ack_n && (!in_win || misaligned(req_q.size, off));
  end

  assign bus.bus_err = err_q;
`endif

endmodule

// File: tb/tb_ls_bus_responder.sv
// Bench for ls_bus_responder: one DUT with two wait states, one with none,
// checked against a byte-addressed memory model of the responder window.
module tb_ls_bus_responder;
  import ls_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Model memory per DUT: index 0 -> WAIT_CYCLES=2, index 1 -> WAIT_CYCLES=0
  logic [31:0] mdl [2][1024];

  always #5 clk = ~clk;

  ls_bus_responder_if #(.ADDR_W(16)) bi2 ();
  ls_bus_responder_if #(.ADDR_W(16)) bi0 ();

  ls_bus_responder #(.ADDR_W(16), .BASE_ADDR(32'h4000), .MEM_DEPTH(1024), .WAIT_CYCLES(2))
    dut2 (.clk(clk), .rst(rst), .bus(bi2));
  ls_bus_responder #(.ADDR_W(16), .BASE_ADDR(32'h4000), .MEM_DEPTH(1024), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bi0));

  // ---------------- reference model ----------------
  function automatic bit m_in_win(input logic [15:0] a);
    return (a >= 16'h4000) && (a <= 16'h4FFF);
  endfunction

  function automatic bit m_misal(input logic [1:0] sz, input logic [15:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic int m_idx(input logic [15:0] a);
    return int'(a - 16'h4000) / 4;
  endfunction

  function automatic void m_write(input int s, input logic [15:0] a, input logic [31:0] d, input logic [1:0] sz);
    int idx, off;
    if (!m_in_win(a) || m_misal(sz, a)) return;
    idx = m_idx(a);
    off = int'(a % 4);
    if (sz == 2'd0)      mdl[s][idx][8*off +: 8]  = d[7:0];
    else if (sz == 2'd1) mdl[s][idx][8*off +: 16] = d[15:0];
    else                 mdl[s][idx] = d;
  endfunction

  function automatic logic [31:0] m_read(input int s, input logic [15:0] a);
    if (!m_in_win(a)) return 32'h0;
    return mdl[s][m_idx(a)];
  endfunction

  function automatic int exp_lat(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  // ---------------- bus access helpers ----------------
  task automatic drive(input int s, input logic en, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [1:0] sz);
    if (s == 0) begin
      bi2.ls_bus_en = en; bi2.ls_bus_wr_en = wr; bi2.ls_bus_addr = a;
      bi2.ls_bus_wr_data = d; bi2.ls_access_size = sz;
    end else begin
      bi0.ls_bus_en = en; bi0.ls_bus_wr_en = wr; bi0.ls_bus_addr = a;
      bi0.ls_bus_wr_data = d; bi0.ls_access_size = sz;
    end
  endtask

  function automatic logic get_ack(input int s);
    return (s == 0) ? bi2.bus_ack : bi0.bus_ack;
  endfunction

  function automatic logic [31:0] get_rd(input int s);
    return (s == 0) ? bi2.ext_read_data : bi0.ext_read_data;
  endfunction

  function automatic logic get_busy(input int s);
    return (s == 0) ? bi2.bus_busy : bi0.bus_busy;
  endfunction

  function automatic logic get_err(input int s);
`ifdef LS_BUS_RESP_ERR_EN
    return (s == 0) ? bi2.bus_err : bi0.bus_err;
`else
    return 1'b0 & s[0];
`endif
  endfunction

  // Called #1 after a posedge with the DUT in IDLE; returns in the IDLE cycle after the ack.
  // lat = cycle of bus_ack counted from the sampling cycle (0 on timeout).
  task automatic txn(input int s, input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [1:0] sz, output int lat, output logic [31:0] rd,
                     output logic er, output logic ack_after);
    bit done;
    lat = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
    drive(s, 1'b1, wr, a, d, sz);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (get_ack(s)) begin
        lat = n; rd = get_rd(s); er = get_err(s); done = 1'b1;
      end
    end
    drive(s, 1'b0, 1'b0, a, d, sz);
    @(posedge clk); #1;
    ack_after = get_ack(s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0, 2'd0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0, 2'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (get_ack(s) !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d: got %b expected 0", s, get_ack(s)); end
      checks++; if (get_rd(s) !== 32'h0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h expected 0", s, get_rd(s)); end
      checks++; if (get_busy(s) !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, get_busy(s)); end
`ifdef LS_BUS_RESP_ERR_EN
      checks++; if (get_err(s) !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b expected 0", s, get_err(s)); end
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, aa;
    txn(0, 1'b1, 16'h4010, 32'hDEADBEEF, SZ_WORD, lat, rd, er, aa);
    m_write(0, 16'h4010, 32'hDEADBEEF, SZ_WORD);
    checks++; if (lat !== 4) begin errors++; $display("FAIL word_wr_lat: got %0d expected 4", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_wr_rdata: got %h expected 0", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL word_wr_ack_width: got %b expected 0", aa); end
    txn(0, 1'b0, 16'h4010, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL word_rd_lat: got %0d expected 4", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_data: got %h expected deadbeef", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL word_rd_ack_width: got %b expected 0", aa); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (get_rd(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", get_rd(0)); end
    checks++; if (get_busy(0) !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", get_busy(0)); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er, aa;
    txn(0, 1'b1, 16'h4020, 32'h11223344, SZ_WORD, lat, rd, er, aa);
    m_write(0, 16'h4020, 32'h11223344, SZ_WORD);
    txn(0, 1'b1, 16'h4022, 32'h000000AB, SZ_BYTE, lat, rd, er, aa);
    m_write(0, 16'h4022, 32'h000000AB, SZ_BYTE);
    checks++; if (lat !== 4) begin errors++; $display("FAIL byte_wr_lat: got %0d expected 4", lat); end
    txn(0, 1'b0, 16'h4020, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store: got %h expected 11ab3344", rd); end
    checks++; if (rd !== m_read(0, 16'h4020)) begin errors++; $display("FAIL byte_store_model: got %h expected %h", rd, m_read(0, 16'h4020)); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er, aa;
    txn(0, 1'b1, 16'h4020, 32'h11223344, SZ_WORD, lat, rd, er, aa);
    m_write(0, 16'h4020, 32'h11223344, SZ_WORD);
    txn(0, 1'b1, 16'h4022, 32'hFFFFCAFE, SZ_HALF, lat, rd, er, aa);
    m_write(0, 16'h4022, 32'hFFFFCAFE, SZ_HALF);
    txn(0, 1'b0, 16'h4020, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (rd !== 32'hCAFE3344) begin errors++; $display("FAIL half_store: got %h expected cafe3344", rd); end
    txn(0, 1'b1, 16'h4021, 32'h0000BEEF, SZ_HALF, lat, rd, er, aa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL misal_half_lat: got %0d expected 4", lat); end
`ifdef LS_BUS_RESP_ERR_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misal_half_err: got %b expected 1", er); end
`endif
    txn(0, 1'b0, 16'h4020, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (rd !== 32'hCAFE3344) begin errors++; $display("FAIL misal_half_dropped: got %h expected cafe3344", rd); end
`ifdef LS_BUS_RESP_ERR_EN
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL good_read_err: got %b expected 0", er); end
`endif
  endtask

  task automatic test_out_of_window();
    int lat; logic [31:0] rd; logic er, aa;
    txn(0, 1'b0, 16'h2000, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL oow_lat: got %0d expected 4", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oow_rdata: got %h expected 0", rd); end
`ifdef LS_BUS_RESP_ERR_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oow_err: got %b expected 1", er); end
`endif
  endtask

  task automatic test_drop_en_and_reset();
    int lat; logic [31:0] rd; logic er, aa; bit done; int ack_seen;
    // request withdrawn during WAIT still completes
    lat = 0; done = 1'b0;
    drive(0, 1'b1, 1'b1, 16'h4030, 32'h5A5A5A5A, SZ_WORD);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0, SZ_BYTE);
    for (int n = 2; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (get_ack(0)) begin lat = n; done = 1'b1; end
    end
    m_write(0, 16'h4030, 32'h5A5A5A5A, SZ_WORD);
    checks++; if (lat !== 4) begin errors++; $display("FAIL drop_en_ack: got %0d expected 4", lat); end
    @(posedge clk); #1;
    txn(0, 1'b0, 16'h4030, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL drop_en_data: got %h expected 5a5a5a5a", rd); end
    // reset coinciding with the ACCESS cycle of a write
    drive(0, 1'b1, 1'b1, 16'h4030, 32'h12345678, SZ_WORD);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0, SZ_BYTE);
    @(posedge clk); #1;
    checks++; if (get_ack(0) !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", get_ack(0)); end
    checks++; if (get_rd(0) !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", get_rd(0)); end
    checks++; if (get_busy(0) !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", get_busy(0)); end
    rst = 1'b0;
    ack_seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (get_ack(0)) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin errors++; $display("FAIL rst_mid_late_ack: got %0d acks expected 0", ack_seen); end
    txn(0, 1'b0, 16'h4030, 32'h0, SZ_WORD, lat, rd, er, aa);
    checks++; if (rd !== m_read(0, 16'h4030)) begin errors++; $display("FAIL rst_mid_retained: got %h expected %h", rd, m_read(0, 16'h4030)); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2; logic [31:0] rd, rd2; logic er, aa; bit done;
    txn(1, 1'b1, 16'h4040, 32'hA1B2C3D4, SZ_WORD, lat, rd, er, aa);
    m_write(1, 16'h4040, 32'hA1B2C3D4, SZ_WORD);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_wr_lat: got %0d expected 2", lat); end
    txn(1, 1'b1, 16'h4044, 32'h0BADF00D, SZ_WORD, lat, rd, er, aa);
    m_write(1, 16'h4044, 32'h0BADF00D, SZ_WORD);
    lat = 0; lat2 = 0; rd = 32'h0; rd2 = 32'h0; done = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h4040, 32'h0, SZ_WORD);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (get_ack(1)) begin lat = n; rd = get_rd(1); done = 1'b1; end
    end
    // new request presented in the ack cycle
    drive(1, 1'b1, 1'b0, 16'h4044, 32'h0, SZ_WORD);
    done = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (get_ack(1)) begin lat2 = n; rd2 = get_rd(1); done = 1'b1; end
    end
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0, SZ_WORD);
    @(posedge clk); #1;
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first_lat: got %0d expected 2", lat); end
    checks++; if (rd !== m_read(1, 16'h4040)) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", rd, m_read(1, 16'h4040)); end
    checks++; if (lat2 !== 3) begin errors++; $display("FAIL b2b_second_gap: got %0d expected 3", lat2); end
    checks++; if (rd2 !== m_read(1, 16'h4044)) begin errors++; $display("FAIL b2b_second_data: got %h expected %h", rd2, m_read(1, 16'h4044)); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, d, exp_rd; logic er, aa, wr, exp_er; logic [1:0] sz; logic [15:0] a;
    int s, r;
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w <= 16; w++) begin
        a = (w == 16) ? 16'h4FFC : 16'(16'h4000 + 4 * w);
        d = $urandom;
        txn(p, 1'b1, a, d, SZ_WORD, lat, rd, er, aa);
        m_write(p, a, d, SZ_WORD);
      end
    end
    for (int i = 0; i < 160; i++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      d  = $urandom;
      r  = int'($urandom_range(0, 9));
      if (r < 8)       a = 16'(16'h4000 + $urandom_range(0, 63));
      else if (r == 8) a = 16'(16'h4FFC + $urandom_range(0, 3));
      else begin
        case ($urandom_range(0, 2))
          0:       a = 16'(16'h2000 + $urandom_range(0, 255));
          1:       a = 16'(16'h5000 + $urandom_range(0, 3));
          default: a = 16'(16'h3FFC + $urandom_range(0, 3));
        endcase
      end
      exp_rd = wr ? 32'h0 : m_read(s, a);
      exp_er = !m_in_win(a) || m_misal(sz, a);
      txn(s, wr, a, d, sz, lat, rd, er, aa);
      if (wr) m_write(s, a, d, sz);
      checks++; if (lat !== exp_lat(s)) begin errors++; $display("FAIL rnd_lat #%0d dut%0d addr %h: got %0d expected %0d", i, s, a, lat, exp_lat(s)); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata #%0d dut%0d wr %b sz %0d addr %h: got %h expected %h", i, s, wr, sz, a, rd, exp_rd); end
`ifdef LS_BUS_RESP_ERR_EN
      checks++; if (er !== exp_er) begin errors++; $display("FAIL rnd_err #%0d dut%0d addr %h sz %0d: got %b expected %b", i, s, a, sz, er, exp_er); end
`else
      if (exp_er && er) $display("note: unexpected err sample");
`endif
    end
    // final sweep of the randomized window against the model
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 16; w++) begin
        a = 16'(16'h4000 + 4 * w);
        txn(p, 1'b0, a, 32'h0, SZ_WORD, lat, rd, er, aa);
        checks++; if (rd !== m_read(p, a)) begin errors++; $display("FAIL sweep dut%0d addr %h: got %h expected %h", p, a, rd, m_read(p, a)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_out_of_window();
    test_drop_en_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
